// File: rtl/expl_axi_sram_ctrl_if.sv
// AXI bundle between the e203 expl_axi master and the SRAM controller.
// Master drives requests and write data; slave drives ready and responses.
interface expl_axi_sram_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              expl_axi_arvalid;
   logic              expl_axi_arready;
   logic [ADDR_W-1:0] expl_axi_araddr;
   logic [1:0]        expl_axi_arburst;
   logic [3:0]        expl_axi_arlen;
   logic [2:0]        expl_axi_arsize;
   logic [3:0]        expl_axi_arcache;
   logic [2:0]        expl_axi_arprot;
   logic [1:0]        expl_axi_arlock;
   logic              expl_axi_awvalid;
   logic              expl_axi_awready;
   logic [ADDR_W-1:0] expl_axi_awaddr;
   logic [1:0]        expl_axi_awburst;
   logic [3:0]        expl_axi_awlen;
   logic [2:0]        expl_axi_awsize;
   logic [3:0]        expl_axi_awcache;
   logic [2:0]        expl_axi_awprot;
   logic [1:0]        expl_axi_awlock;
   logic              expl_axi_wvalid;
   logic              expl_axi_wready;
   logic [DATA_W-1:0] expl_axi_wdata;
   logic [DATA_W/8-1:0] expl_axi_wstrb;
   logic              expl_axi_wlast;
   logic              expl_axi_rvalid;
   logic              expl_axi_rready;
   logic [DATA_W-1:0] expl_axi_rdata;
   logic [1:0]        expl_axi_rresp;
   logic              expl_axi_rlast;
   logic              expl_axi_bvalid;
   logic              expl_axi_bready;
   logic [1:0]        expl_axi_bresp;

   modport master (
      output expl_axi_arvalid, expl_axi_araddr, expl_axi_arburst,
             expl_axi_arlen, expl_axi_arsize, expl_axi_arcache,
             expl_axi_arprot, expl_axi_arlock,
             expl_axi_awvalid, expl_axi_awaddr, expl_axi_awburst,
             expl_axi_awlen, expl_axi_awsize, expl_axi_awcache,
             expl_axi_awprot, expl_axi_awlock,
             expl_axi_wvalid, expl_axi_wdata, expl_axi_wstrb,
             expl_axi_wlast, expl_axi_rready, expl_axi_bready,
      input  expl_axi_arready, expl_axi_awready, expl_axi_wready,
             expl_axi_rvalid, expl_axi_rdata, expl_axi_rresp,
             expl_axi_rlast, expl_axi_bvalid, expl_axi_bresp
   );

   modport slave (
      input  expl_axi_arvalid, expl_axi_araddr, expl_axi_arburst,
             expl_axi_arlen, expl_axi_arsize, expl_axi_arcache,
             expl_axi_arprot, expl_axi_arlock,
             expl_axi_awvalid, expl_axi_awaddr, expl_axi_awburst,
             expl_axi_awlen, expl_axi_awsize, expl_axi_awcache,
             expl_axi_awprot, expl_axi_awlock,
             expl_axi_wvalid, expl_axi_wdata, expl_axi_wstrb,
             expl_axi_wlast, expl_axi_rready, expl_axi_bready,
      output expl_axi_arready, expl_axi_awready, expl_axi_wready,
             expl_axi_rvalid, expl_axi_rdata, expl_axi_rresp,
             expl_axi_rlast, expl_axi_bvalid, expl_axi_bresp
   );
endinterface

// File: rtl/expl_axi_sram_ctrl.sv
// AXI slave sequencing one transaction at a time onto a 1-port sync SRAM.
// Optional burst range check / SLVERR: define EXPL_AXI_SRAM_ERR_EN.
module expl_axi_sram_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MEM_AW = 12,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h2000_0000
) (
   input  logic                clk_16M,
   input  logic                rst,
   expl_axi_sram_ctrl_if.slave axi,
   output logic                sram_cs,
   output logic                sram_we,
   output logic [DATA_W/8-1:0] sram_wem,
   output logic [MEM_AW-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_wdata,
   input  logic [DATA_W-1:0]   sram_rdata
);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RD_ISSUE = 3'd1;
   localparam logic [2:0] RD_DATA  = 3'd2;
   localparam logic [2:0] WR_DATA  = 3'd3;
   localparam logic [2:0] WR_RESP  = 3'd4;
   localparam logic PRIO_RD = 1'b0;
   localparam logic PRIO_WR = 1'b1;

   logic [2:0]        state;
   logic              prio;
   logic [MEM_AW-1:0] waddr;
   logic [MEM_AW-1:0] step;
   logic [3:0]        len_q;
   logic [3:0]        beat;
   logic [1:0]        burst_q;
   logic              err_q;
   logic              fresh;
   logic [DATA_W-1:0] rhold;
   logic              idle;
   logic              ar_hs;
   logic              aw_hs;
   logic              ar_err;
   logic              aw_err;
   logic              last;
   logic              wr_go;
   logic [ADDR_W-1:0] ar_off;
   logic [ADDR_W-1:0] aw_off;
   logic              unused;

   assign idle   = (state == IDLE) && !rst;
   assign ar_off = axi.expl_axi_araddr - BASE_ADDR;
   assign aw_off = axi.expl_axi_awaddr - BASE_ADDR;
   assign last   = (beat == len_q);
   assign step   = (burst_q == 2'b00) ? '0 : MEM_AW'(1);
   assign ar_hs  = axi.expl_axi_arvalid && axi.expl_axi_arready;
   assign aw_hs  = axi.expl_axi_awvalid && axi.expl_axi_awready;
   assign wr_go  = (state == WR_DATA) && axi.expl_axi_wvalid;

`ifdef EXPL_AXI_SRAM_ERR_EN
   localparam int XW = ADDR_W + 6;
   localparam logic [XW-1:0] LIMIT = XW'(1) << (MEM_AW + 2);
   localparam logic [XW-1:0] ONE   = XW'(1);

   function automatic logic range_err(input logic [ADDR_W-1:0] a,
                                      input logic [3:0] l);
      logic [XW-1:0] end_b;
      end_b = XW'(a - BASE_ADDR) + ((XW'(l) + ONE) << 2);
      return (a < BASE_ADDR) || (end_b > LIMIT);
   endfunction

   assign ar_err = range_err(axi.expl_axi_araddr, axi.expl_axi_arlen);
   assign aw_err = range_err(axi.expl_axi_awaddr, axi.expl_axi_awlen);
`else
   assign ar_err = 1'b0;
   assign aw_err = 1'b0;
`endif

   assign unused = ^{axi.expl_axi_arsize, axi.expl_axi_arcache,
                     axi.expl_axi_arprot, axi.expl_axi_arlock,
                     axi.expl_axi_awsize, axi.expl_axi_awcache,
                     axi.expl_axi_awprot, axi.expl_axi_awlock,
                     axi.expl_axi_wlast,
                     ar_off[ADDR_W-1:MEM_AW+2], ar_off[1:0],
                     aw_off[ADDR_W-1:MEM_AW+2], aw_off[1:0]};

   // Handshake readies, responses and SRAM strobes decoded from state.
   always_comb begin
      axi.expl_axi_arready = idle && axi.expl_axi_arvalid &&
                             (!axi.expl_axi_awvalid || prio == PRIO_RD);
      axi.expl_axi_awready = idle && axi.expl_axi_awvalid &&
                             (!axi.expl_axi_arvalid || prio == PRIO_WR);
      axi.expl_axi_wready  = (state == WR_DATA);
      axi.expl_axi_rvalid  = (state == RD_DATA);
      axi.expl_axi_rlast   = (state == RD_DATA) && last;
      axi.expl_axi_rresp   = ((state == RD_DATA) && err_q) ? 2'b10 : 2'b00;
      axi.expl_axi_rdata   = '0;
      if ((state == RD_DATA) && !err_q)
         axi.expl_axi_rdata = fresh ? sram_rdata : rhold;
      axi.expl_axi_bvalid  = (state == WR_RESP);
      axi.expl_axi_bresp   = ((state == WR_RESP) && err_q) ? 2'b10 : 2'b00;
      sram_cs    = !err_q && ((state == RD_ISSUE) || wr_go);
      sram_we    = !err_q && wr_go;
      sram_wem   = sram_we ? axi.expl_axi_wstrb : '0;
      sram_wdata = sram_we ? axi.expl_axi_wdata : '0;
      sram_addr  = sram_cs ? waddr : '0;
   end

   // Transaction FSM: arbitration, beat counting, address stepping.
   always_ff @(posedge clk_16M) begin
      if (rst) begin
         state   <= IDLE;
         prio    <= PRIO_RD;
         waddr   <= '0;
         len_q   <= '0;
         beat    <= '0;
         burst_q <= '0;
         err_q   <= 1'b0;
         fresh   <= 1'b0;
         rhold   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               beat <= '0;
               if (ar_hs) begin
                  state   <= RD_ISSUE;
                  prio    <= PRIO_WR;
                  waddr   <= ar_off[MEM_AW+1:2];
                  len_q   <= axi.expl_axi_arlen;
                  burst_q <= axi.expl_axi_arburst;
                  err_q   <= ar_err;
               end else if (aw_hs) begin
                  state   <= WR_DATA;
                  prio    <= PRIO_RD;
                  waddr   <= aw_off[MEM_AW+1:2];
                  len_q   <= axi.expl_axi_awlen;
                  burst_q <= axi.expl_axi_awburst;
                  err_q   <= aw_err;
               end
            end
            RD_ISSUE: begin
               state <= RD_DATA;
               fresh <= 1'b1;
            end
            RD_DATA: begin
               fresh <= 1'b0;
               if (fresh) rhold <= sram_rdata;
               if (axi.expl_axi_rready) begin
                  if (last) begin
                     state <= IDLE;
                  end else begin
                     state <= RD_ISSUE;
                     beat  <= beat + 4'd1;
                     waddr <= waddr + step;
                  end
               end
            end
            WR_DATA: begin
               if (axi.expl_axi_wvalid) begin
                  if (last) begin
                     state <= WR_RESP;
                  end else begin
                     beat  <= beat + 4'd1;
                     waddr <= waddr + step;
                  end
               end
            end
            WR_RESP: begin
               if (axi.expl_axi_bready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/expl_axi_sram_ctrl.md
Name: expl_axi_sram_ctrl

Overview:
AXI slave controller on the e203 expl_axi master port. It sequences AR/AW/W/R/B channel handshakes onto one single-port synchronous SRAM. It arbitrates between pending read and write transactions and runs one transaction at a time. It sits in the system top beside u_e203_zs, on the 16 MHz core clock.

Parameters:
ADDR_W, 32, AXI address width (E203_ADDR_SIZE)
DATA_W, 32, AXI data width (E203_XLEN); strobe width DATA_W/8
MEM_AW, 12, SRAM word-address width (4096 words)
BASE_ADDR, 32'h2000_0000, byte base address of the SRAM window

Ports:
clk_16M  in  1  core clock
rst  in  1  synchronous reset, active-high
expl_axi_arvalid/arready  in/out  1/1  read address handshake
expl_axi_araddr  in  ADDR_W  read byte address
expl_axi_arburst  in  2  burst type
expl_axi_arlen  in  4  beats-1
expl_axi_arsize/arcache/arprot/arlock  in  3/4/3/2  accepted, ignored
expl_axi_awvalid/awready  in/out  1/1  write address handshake
expl_axi_awaddr  in  ADDR_W  write byte address
expl_axi_awburst  in  2  burst type
expl_axi_awlen  in  4  beats-1
expl_axi_awsize/awcache/awprot/awlock  in  3/4/3/2  accepted, ignored
expl_axi_wvalid/wready  in/out  1/1  write data handshake
expl_axi_wdata  in  DATA_W  write data
expl_axi_wstrb  in  DATA_W/8  byte enables
expl_axi_wlast  in  1  ignored for termination
expl_axi_rvalid  out  1  read data valid; rready is in, 1
expl_axi_rdata  out  DATA_W  read data
expl_axi_rresp  out  2  read response
expl_axi_rlast  out  1  last read beat
expl_axi_bvalid  out  1  write response valid; bready is in, 1
expl_axi_bresp  out  2  write response
sram_cs  out  1  SRAM chip select
sram_we  out  1  1 = write
sram_wem  out  DATA_W/8  byte write mask
sram_addr  out  MEM_AW  word address
sram_wdata  out  DATA_W  write data
sram_rdata  in  DATA_W  read data, valid 1 cycle after cs & !we

Behaviour:
- Clock and reset: one clock, clk_16M. Reset is synchronous and active-high on rst.
- Reset values: all outputs are 0. State is IDLE. The priority flag is set to "read first".
- Reset mid-transaction: the in-flight burst is dropped. No further SRAM access occurs. rvalid and bvalid drop the cycle after rst is sampled.
- FSM states: IDLE, RD_ISSUE, RD_DATA, WR_DATA, WR_RESP.
- IDLE:
  - arready = (state==IDLE) & arvalid & (!awvalid | prio==RD).
  - awready = (state==IDLE) & awvalid & (!arvalid | prio==WR).
  - These are combinational from the registered state.
  - On an AR handshake: go to RD_ISSUE, set prio=WR. On an AW handshake: go to WR_DATA, set prio=RD.
  - Address, len and burst are latched at the handshake.
- Address rules:
  - Word address = (addr - BASE_ADDR) >> 2, truncated to MEM_AW (wraps modulo 2^MEM_AW).
  - Size is ignored; every beat is a full word.
- Burst rules:
  - FIXED (00): address is held across beats.
  - INCR (01), WRAP (10) and reserved (11): address increments by 1 word per beat.
  - Beat counter counts 0..len.
- RD_ISSUE:
  - Drive sram_cs=1, sram_we=0 for one cycle, then go to RD_DATA.
- RD_DATA:
  - rvalid=1 and rdata is captured from sram_rdata. Both are held stable until rready.
  - rlast=1 when beat==len. rresp=00.
  - On handshake, non-last beat: go to RD_ISSUE with the address advanced.
  - On handshake, last beat: go to IDLE.
- Read timing:
  - AR handshake in cycle T gives the first rvalid at T+2.
  - A beat handshake in cycle N gives the next rvalid at N+2.
- WR_DATA:
  - wready=1.
  - On a W handshake, in the same cycle: sram_cs=1, sram_we=1, sram_wem=wstrb, sram_wdata=wdata, sram_addr=current address.
  - When beat==len: go to WR_RESP. wlast is not checked.
- WR_RESP:
  - bvalid=1, bresp=00, held until bready. Then go to IDLE.
- SRAM idle outputs: sram_cs=0 in every cycle not listed above.
- Simultaneous events: arvalid and awvalid in the same IDLE cycle grant alternately. With continuous traffic, reads and writes interleave 1:1.
- Ordering: no new AR or AW is accepted while a transaction is open.

Optional Feature:
Macro EXPL_AXI_SRAM_ERR_EN.
- Defined:
  - The whole burst is range-checked at the address handshake.
  - Out of range means addr < BASE_ADDR, or (addr - BASE_ADDR) + 4*(len+1) > 4*2^MEM_AW.
  - Out-of-range reads: no SRAM access is made, each beat returns rdata=0 and rresp=10 (SLVERR), with the same beat timing.
  - Out-of-range writes: sram_cs is held 0, W beats are still accepted, and bresp=10.
- Undefined: no range check. Addresses wrap and responses are always 00.

Test Plan:
- Single read: AR addr=BASE+0x10, len=0, SRAM word 4 = 0xDEADBEEF -> rvalid at T+2, rdata=0xDEADBEEF, rlast=1, rresp=00.
- INCR write then read-back: AW BASE, len=3, data 0x11,0x22,0x33,0x44, wstrb=F -> one bvalid with bresp=00. Then a 4-beat read returns 0x11..0x44, with rlast on beat 3 only.
- FIXED write with partial strobes: len=1, wstrb=0x1 then 0x8, same word address -> sram_addr is constant and sram_wem goes 0001 then 1000.
- Backpressure: 4-beat read with rready low for 5 cycles on beat 1 -> rdata and rvalid are held stable, no extra sram_cs pulses occur, and the beat order is preserved.
- Arbitration: arvalid and awvalid held high together for 4 transactions after reset -> grant order is R, W, R, W.
- Reset mid-burst: rst asserted during beat 2 of an 8-beat read -> the next cycle has all outputs 0 and state IDLE, and a new AR is accepted normally.
- (ERR_EN) Read at addr BASE+0x4000 with MEM_AW=12 -> rresp=10, rdata=0, no sram_cs.
